// File: rtl/kd_pkg.sv
// Shared types and derived constants for the query-patch memory path.
package kd_pkg;
  localparam int DATA_WIDTH = 11;
  localparam int PATCH_SIZE = 5;
  localparam int PATCH_W    = PATCH_SIZE * DATA_WIDTH;
  localparam int ROW_SIZE   = 24;
  localparam int COL_SIZE   = 17;
  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
  localparam int ADDRW      = $clog2(NUM_QUERYS);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NUM_QUERYS - 1);

  typedef logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] patch_t;

  typedef enum logic { ACC = 1'b0, WBS = 1'b1 } owner_e;

  typedef enum logic [1:0] {
    ACC_OWN = 2'd0,
    WBS_OWN = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  function automatic logic addr_in_range(input logic [ADDRW-1:0] addr);
    return addr <= LAST_ADDR;
  endfunction

  function automatic state_e owner_state(input owner_e owner);
    return (owner == WBS) ? WBS_OWN : ACC_OWN;
  endfunction
endpackage

// File: rtl/qp_rd_tracker.sv
// Tracks the one outstanding SRAM read, steers its data to the requesting
// master and holds the last Wishbone read result.
module qp_rd_tracker
  import kd_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   rd_issue_i,
  input  owner_e rd_src_i,
  input  logic   rd_err_i,
  input  patch_t sram_dout_i,
  output logic   rd_pend_o,
  output logic   acc_rvalid_o,
  output patch_t acc_rpatch_o,
  output patch_t wbs_rpatch_o
);
  logic   rd_pend_q;
  logic   rd_err_q;
  owner_e rd_src_q;
  patch_t wbs_rpatch_q;
  patch_t rd_data;

  // Out-of-range reads never touched the SRAM, so they return zero.
  assign rd_data = rd_err_q ? '0 : sram_dout_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q    <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_src_q     <= ACC;
      wbs_rpatch_q <= '0;
    end else begin
      rd_pend_q <= rd_issue_i;
      if (rd_issue_i) begin
        rd_src_q <= rd_src_i;
        rd_err_q <= rd_err_i;
      end
      if (rd_pend_q && (rd_src_q == WBS)) begin
        wbs_rpatch_q <= rd_data;
      end
    end
  end

  assign rd_pend_o    = rd_pend_q;
  assign acc_rvalid_o = rd_pend_q && (rd_src_q == ACC);
  assign acc_rpatch_o = acc_rvalid_o ? rd_data : '0;
  assign wbs_rpatch_o = wbs_rpatch_q;
endmodule

// File: rtl/qp_mem_arbiter.sv
// Arbitrates the single-port query-patch SRAM between the Wishbone load path
// and the accelerator, switching owner through a read-draining state.
module qp_mem_arbiter
  import kd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wbs_mode,
  input  logic               wbs_qp_mem_csb0,
  input  logic               wbs_qp_mem_web0,
  input  logic [ADDRW-1:0]   wbs_qp_mem_addr0,
  input  logic [PATCH_W-1:0] wbs_qp_mem_wpatch0,
  output logic [PATCH_W-1:0] wbs_qp_mem_rpatch0,
  input  logic               acc_req_valid,
  output logic               acc_req_ready,
  input  logic               acc_we,
  input  logic [ADDRW-1:0]   acc_addr,
  input  logic [PATCH_W-1:0] acc_wpatch,
  output logic               acc_rvalid,
  output logic [PATCH_W-1:0] acc_rpatch,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [ADDRW-1:0]   sram_addr0,
  output logic [PATCH_W-1:0] sram_din0,
  input  logic [PATCH_W-1:0] sram_dout0,
  output logic               addr_err,
  output logic [15:0]        stall_cnt,
  output state_e             dbg_state_o
);
  // Accelerator handshake: a request transfers in any cycle where
  // acc_req_valid && acc_req_ready; ready is high only while the accelerator
  // owns the memory and never depends on valid.
  state_e             state_q;
  owner_e             drain_tgt_q;
  logic               addr_err_q;
  logic [15:0]        stall_cnt_q;

  logic               req_en;
  logic               req_web;
  logic [ADDRW-1:0]   req_addr;
  logic [PATCH_W-1:0] req_din;
  owner_e             req_src;
  logic               req_ok;
  logic               rd_issue;
  logic               rd_pend;
  logic               stall;
  patch_t             acc_rpatch_w;
  patch_t             wbs_rpatch_w;

  always_comb begin
    req_en   = 1'b0;
    req_web  = 1'b1;
    req_addr = '0;
    req_din  = '0;
    req_src  = ACC;
    if (rst_n) begin
      unique case (state_q)
        ACC_OWN: begin
          if (acc_req_valid) begin
            req_en   = 1'b1;
            req_web  = ~acc_we;
            req_addr = acc_addr;
            req_din  = acc_wpatch;
          end
        end
        WBS_OWN: begin
          req_en   = ~wbs_qp_mem_csb0;
          req_web  = wbs_qp_mem_web0;
          req_addr = wbs_qp_mem_addr0;
          req_din  = wbs_qp_mem_wpatch0;
          req_src  = WBS;
        end
        default: ;
      endcase
    end
  end

  assign req_ok        = addr_in_range(req_addr);
  assign rd_issue      = req_en && req_web;
  assign acc_req_ready = rst_n && (state_q == ACC_OWN);
  assign stall         = acc_req_valid && !acc_req_ready;

  assign sram_csb0  = ~(req_en && req_ok);
  assign sram_web0  = req_web;
  assign sram_addr0 = req_addr;
  assign sram_din0  = req_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC_OWN;
      drain_tgt_q <= ACC;
    end else begin
      unique case (state_q)
        ACC_OWN: if (wbs_mode) begin
          state_q     <= DRAIN;
          drain_tgt_q <= WBS;
        end
        WBS_OWN: if (!wbs_mode) begin
          state_q     <= DRAIN;
          drain_tgt_q <= ACC;
        end
        DRAIN: if (!rd_pend) begin
          // Mode still requests the target: complete; otherwise abort back.
          if (wbs_mode == (drain_tgt_q == WBS)) state_q <= owner_state(drain_tgt_q);
          else state_q <= owner_state((drain_tgt_q == WBS) ? ACC : WBS);
        end
        default: state_q <= ACC_OWN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (req_en && !req_ok) addr_err_q <= 1'b1;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  qp_rd_tracker u_rd_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_issue_i   (rd_issue),
    .rd_src_i     (req_src),
    .rd_err_i     (!req_ok),
    .sram_dout_i  (sram_dout0),
    .rd_pend_o    (rd_pend),
    .acc_rvalid_o (acc_rvalid),
    .acc_rpatch_o (acc_rpatch_w),
    .wbs_rpatch_o (wbs_rpatch_w)
  );

  assign acc_rpatch         = acc_rpatch_w;
  assign wbs_qp_mem_rpatch0 = wbs_rpatch_w;
  assign addr_err           = addr_err_q;
  assign stall_cnt          = stall_cnt_q;
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_qp_mem_arbiter.sv
// Bench for qp_mem_arbiter: SRAM model, accelerator read scoreboard and
// directed sequences for ownership, hold, range, stall and reset behaviour.
module tb_qp_mem_arbiter;
  import kd_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               wbs_mode;
  logic               wbs_qp_mem_csb0;
  logic               wbs_qp_mem_web0;
  logic [ADDRW-1:0]   wbs_qp_mem_addr0;
  logic [PATCH_W-1:0] wbs_qp_mem_wpatch0;
  logic [PATCH_W-1:0] wbs_qp_mem_rpatch0;
  logic               acc_req_valid;
  logic               acc_req_ready;
  logic               acc_we;
  logic [ADDRW-1:0]   acc_addr;
  logic [PATCH_W-1:0] acc_wpatch;
  logic               acc_rvalid;
  logic [PATCH_W-1:0] acc_rpatch;
  logic               sram_csb0;
  logic               sram_web0;
  logic [ADDRW-1:0]   sram_addr0;
  logic [PATCH_W-1:0] sram_din0;
  logic [PATCH_W-1:0] sram_dout0;
  logic               addr_err;
  logic [15:0]        stall_cnt;
  state_e             dbg_state;

  int checks   = 0;
  int failures = 0;
  int sram_wr_cnt = 0;
  logic [PATCH_W-1:0] exp_q[$];
  logic [PATCH_W-1:0] ref_mem [int];
  logic [PATCH_W-1:0] sram_mem [0:511];

  localparam logic [PATCH_W-1:0] D5 = 55'h12_3456_789A_BCDE;
  localparam logic [PATCH_W-1:0] WB_V = 55'h00_1010_DEAD_BEEF;

  qp_mem_arbiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wbs_mode           (wbs_mode),
    .wbs_qp_mem_csb0    (wbs_qp_mem_csb0),
    .wbs_qp_mem_web0    (wbs_qp_mem_web0),
    .wbs_qp_mem_addr0   (wbs_qp_mem_addr0),
    .wbs_qp_mem_wpatch0 (wbs_qp_mem_wpatch0),
    .wbs_qp_mem_rpatch0 (wbs_qp_mem_rpatch0),
    .acc_req_valid      (acc_req_valid),
    .acc_req_ready      (acc_req_ready),
    .acc_we             (acc_we),
    .acc_addr           (acc_addr),
    .acc_wpatch         (acc_wpatch),
    .acc_rvalid         (acc_rvalid),
    .acc_rpatch         (acc_rpatch),
    .sram_csb0          (sram_csb0),
    .sram_web0          (sram_web0),
    .sram_addr0         (sram_addr0),
    .sram_din0          (sram_din0),
    .sram_dout0         (sram_dout0),
    .addr_err           (addr_err),
    .stall_cnt          (stall_cnt),
    .dbg_state_o        (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 1-cycle read latency, dout holds between reads
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        sram_mem[sram_addr0] <= sram_din0;
        sram_wr_cnt <= sram_wr_cnt + 1;
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accelerator response is matched against exp_q
  always @(negedge clk) begin
    if (acc_rvalid) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", 64'(acc_rvalid), 64'd0);
      else chk("acc_rpatch", 64'(acc_rpatch), 64'(exp_q.pop_front()));
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic acc_idle();
    acc_req_valid = 1'b0;
    acc_we        = 1'b0;
    acc_addr      = '0;
    acc_wpatch    = '0;
  endtask

  task automatic wbs_idle();
    wbs_qp_mem_csb0    = 1'b1;
    wbs_qp_mem_web0    = 1'b1;
    wbs_qp_mem_addr0   = '0;
    wbs_qp_mem_wpatch0 = '0;
  endtask

  task automatic acc_drive(input logic we, input logic [ADDRW-1:0] a,
                           input logic [PATCH_W-1:0] d, input bit expect_resp);
    acc_req_valid = 1'b1;
    acc_we        = we;
    acc_addr      = a;
    acc_wpatch    = d;
    if (we) begin
      if (a < ADDRW'(NUM_QUERYS)) ref_mem[int'(a)] = d;
    end else if (expect_resp) begin
      exp_q.push_back((a < ADDRW'(NUM_QUERYS)) ? ref_mem[int'(a)] : '0);
    end
  endtask

  task automatic wbs_drive(input logic web, input logic [ADDRW-1:0] a, input logic [PATCH_W-1:0] d);
    wbs_qp_mem_csb0    = 1'b0;
    wbs_qp_mem_web0    = web;
    wbs_qp_mem_addr0   = a;
    wbs_qp_mem_wpatch0 = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  64'(dbg_state), 64'(ACC_OWN));
    chk({tag, "_ready"},  64'(acc_req_ready), 64'd0);
    chk({tag, "_rvalid"}, 64'(acc_rvalid), 64'd0);
    chk({tag, "_rpatch"}, 64'(acc_rpatch), 64'd0);
    chk({tag, "_csb"},    64'(sram_csb0), 64'd1);
    chk({tag, "_web"},    64'(sram_web0), 64'd1);
    chk({tag, "_addr"},   64'(sram_addr0), 64'd0);
    chk({tag, "_din"},    64'(sram_din0), 64'd0);
    chk({tag, "_wbs_rp"}, 64'(wbs_qp_mem_rpatch0), 64'd0);
    chk({tag, "_err"},    64'(addr_err), 64'd0);
    chk({tag, "_stall"},  64'(stall_cnt), 64'd0);
  endtask

  initial begin
    int wr_before;
    logic [ADDRW-1:0] wr_addrs [6];
    wr_addrs = '{9'd5, 9'd7, 9'd10, 9'd11, 9'd12, 9'd13};

    rst_n    = 1'b0;
    wbs_mode = 1'b0;
    acc_idle();
    wbs_idle();
    #3;
    chk_reset_vals("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_rst", 64'(acc_req_ready), 64'd1);

    // Accelerator writes then reads
    foreach (wr_addrs[i]) begin
      acc_drive(1'b1, wr_addrs[i], (i == 0) ? D5 : 55'({$urandom(), $urandom()}), 1'b0);
      if (i == 0) begin
        #1;
        chk("acc_wr_csb", 64'(sram_csb0), 64'd0);
        chk("acc_wr_web", 64'(sram_web0), 64'd0);
        chk("acc_wr_addr", 64'(sram_addr0), 64'd5);
        chk("acc_wr_din", 64'(sram_din0), 64'(D5));
      end
      step();
    end
    acc_drive(1'b0, 9'd5, '0, 1'b1);
    #1 chk("acc_rd_web", 64'(sram_web0), 64'd1);
    step();
    acc_idle();
    chk("acc_rvalid_n1", 64'(acc_rvalid), 64'd1);
    chk("acc_rpatch_n1", 64'(acc_rpatch), 64'(D5));
    step();
    chk("acc_rvalid_n2", 64'(acc_rvalid), 64'd0);
    chk("stall_zero", 64'(stall_cnt), 64'd0);

    for (int i = 0; i < 4; i++) begin
      acc_drive(1'b0, ADDRW'(10 + i), '0, 1'b1);
      step();
      chk("b2b_rvalid", 64'(acc_rvalid), 64'd1);
    end
    acc_idle();
    step();
    chk("b2b_done", 64'(acc_rvalid), 64'd0);

    // Out-of-range and last legal address
    chk("err_clear", 64'(addr_err), 64'd0);
    acc_drive(1'b0, 9'd408, '0, 1'b1);
    #1;
    chk("oor_csb", 64'(sram_csb0), 64'd1);
    chk("oor_ready", 64'(acc_req_ready), 64'd1);
    step();
    acc_idle();
    chk("oor_rvalid", 64'(acc_rvalid), 64'd1);
    chk("oor_rpatch", 64'(acc_rpatch), 64'd0);
    chk("oor_err", 64'(addr_err), 64'd1);
    acc_drive(1'b1, 9'd407, 55'({$urandom(), $urandom()}), 1'b0);
    #1 chk("addr407_csb", 64'(sram_csb0), 64'd0);
    step();
    acc_drive(1'b0, 9'd407, '0, 1'b1);
    step();
    acc_idle();
    step();
    chk("err_sticky", 64'(addr_err), 64'd1);

    // Mode switch with a read in flight
    acc_drive(1'b0, 9'd7, '0, 1'b1);
    wbs_mode = 1'b1;
    step();
    acc_idle();
    chk("sw_state_drain", 64'(dbg_state), 64'(DRAIN));
    chk("sw_rvalid", 64'(acc_rvalid), 64'd1);
    chk("sw_ready", 64'(acc_req_ready), 64'd0);
    step();
    chk("sw_state_drain2", 64'(dbg_state), 64'(DRAIN));
    step();
    chk("sw_state_wbs", 64'(dbg_state), 64'(WBS_OWN));
    chk("wbs_ready", 64'(acc_req_ready), 64'd0);

    // Stall counting and saturation
    acc_req_valid = 1'b1;
    #1 chk("stall_no_sram", 64'(sram_csb0), 64'd1);
    repeat (20) step();
    acc_idle();
    chk("stall_20", 64'(stall_cnt), 64'd20);
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    acc_req_valid = 1'b1;
    repeat (3) step();
    acc_idle();
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);

    // Wishbone write, read and hold
    wbs_drive(1'b0, 9'd2, WB_V);
    #1;
    chk("wbs_wr_csb", 64'(sram_csb0), 64'd0);
    chk("wbs_wr_web", 64'(sram_web0), 64'd0);
    chk("wbs_wr_addr", 64'(sram_addr0), 64'd2);
    chk("wbs_wr_din", 64'(sram_din0), 64'(WB_V));
    step();
    wbs_drive(1'b1, 9'd2, '0);
    step();
    wbs_idle();
    chk("wbs_rp_n1", 64'(wbs_qp_mem_rpatch0), 64'd0);
    step();
    chk("wbs_rp_n2", 64'(wbs_qp_mem_rpatch0), 64'(WB_V));
    repeat (10) step();
    chk("wbs_rp_idle", 64'(wbs_qp_mem_rpatch0), 64'(WB_V));
    wbs_drive(1'b0, 9'd3, 55'h7F_0000_1111_2222);
    step();
    wbs_idle();
    step();
    chk("wbs_rp_after_wr", 64'(wbs_qp_mem_rpatch0), 64'(WB_V));
    wbs_drive(1'b1, 9'd500, '0);
    #1 chk("wbs_oor_csb", 64'(sram_csb0), 64'd1);
    step();
    wbs_idle();
    step();
    chk("wbs_oor_rp", 64'(wbs_qp_mem_rpatch0), 64'd0);

    // Return to accelerator ownership
    wbs_mode = 1'b0;
    step();
    chk("back_drain", 64'(dbg_state), 64'(DRAIN));
    step();
    chk("back_acc", 64'(dbg_state), 64'(ACC_OWN));

    // One-cycle mode pulse aborts the drain; Wishbone write stays blocked
    wr_before = sram_wr_cnt;
    wbs_drive(1'b0, 9'd9, 55'h55_5555_5555_5555);
    wbs_mode = 1'b1;
    step();
    chk("abort_drain", 64'(dbg_state), 64'(DRAIN));
    chk("abort_csb", 64'(sram_csb0), 64'd1);
    wbs_mode = 1'b0;
    step();
    wbs_idle();
    chk("abort_acc", 64'(dbg_state), 64'(ACC_OWN));
    chk("abort_no_wr", 64'(sram_wr_cnt), 64'(wr_before));

    // Reset while a read is pending: no response may follow
    acc_drive(1'b0, 9'd5, '0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    acc_idle();
    #1 chk_reset_vals("midrd");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_rvalid", 64'(acc_rvalid), 64'd0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qp_mem_arbiter.md
Name: qp_mem_arbiter

Overview:
- Sits directly downstream of the Wishbone slave controller's query-patch memory port.
- Arbitrates the single-port query-patch SRAM between two masters: the Wishbone debug/load path (wbs_qp_mem_*) and the accelerator's query fetch/store path (acc_*).
- Ownership follows wbs_mode. A DRAIN state retires in-flight reads before ownership changes.
- Handles the SRAM's 1-cycle read latency, holds Wishbone read data, and flags out-of-range addresses.

Parameters:
- DATA_WIDTH, 11, bits per patch element
- PATCH_SIZE, 5, elements per patch (patch word = 55 bits)
- ROW_SIZE, 24, query rows
- COL_SIZE, 17, query columns
- NUM_QUERYS, ROW_SIZE*COL_SIZE (408), number of valid SRAM entries
- ADDRW, $clog2(NUM_QUERYS) (9), address width

Ports:
- clk in 1: single clock
- rst_n in 1: asynchronous active-low reset
- wbs_mode in 1: 1 = Wishbone owns the memory, 0 = accelerator owns it
- wbs_qp_mem_csb0 in 1: Wishbone chip select, active-low
- wbs_qp_mem_web0 in 1: Wishbone write enable, active-low
- wbs_qp_mem_addr0 in ADDRW: Wishbone address
- wbs_qp_mem_wpatch0 in PATCH_SIZE*DATA_WIDTH: Wishbone write data
- wbs_qp_mem_rpatch0 out PATCH_SIZE*DATA_WIDTH: registered, held Wishbone read data
- acc_req_valid in 1: accelerator request valid
- acc_req_ready out 1: accelerator request accepted
- acc_we in 1: accelerator write (1) or read (0)
- acc_addr in ADDRW: accelerator address
- acc_wpatch in PATCH_SIZE*DATA_WIDTH: accelerator write data
- acc_rvalid out 1: accelerator read data valid
- acc_rpatch out PATCH_SIZE*DATA_WIDTH: accelerator read data
- sram_csb0 out 1: SRAM chip select, active-low
- sram_web0 out 1: SRAM write enable, active-low
- sram_addr0 out ADDRW: SRAM address
- sram_din0 out PATCH_SIZE*DATA_WIDTH: SRAM write data
- sram_dout0 in PATCH_SIZE*DATA_WIDTH: SRAM read data, valid the cycle after a read is issued
- addr_err out 1: sticky out-of-range flag
- stall_cnt out 16: saturating count of accelerator stall cycles

Behaviour:
- Reset values:
  - state = ACC_OWN
  - sram_csb0 = 1, sram_web0 = 1, sram_addr0 = 0, sram_din0 = 0
  - acc_req_ready = 0, acc_rvalid = 0, acc_rpatch = 0
  - wbs_qp_mem_rpatch0 = 0
  - addr_err = 0, stall_cnt = 0
  - rd_pend = 0, rd_src = 0
- FSM states: ACC_OWN, WBS_OWN, DRAIN. A register drain_tgt (1 bit) holds the pending owner.
  - ACC_OWN, wbs_mode=1 → DRAIN with drain_tgt=WBS.
  - WBS_OWN, wbs_mode=0 → DRAIN with drain_tgt=ACC.
  - DRAIN, rd_pend=0:
    - wbs_mode matches drain_tgt → that owner's state.
    - wbs_mode reverted → previous owner's state (abort).
  - DRAIN lasts at most 2 cycles. No SRAM access is issued in DRAIN.
- ACC_OWN:
  - acc_req_ready = 1 (combinational).
  - When acc_req_valid: sram_csb0=0, sram_web0=~acc_we, addr and din driven from acc_*.
  - Wishbone port is ignored: writes dropped, rpatch0 holds its last value.
- WBS_OWN:
  - acc_req_ready = 0.
  - SRAM pins pass the wbs_qp_mem_* inputs combinationally.
- Read tracking:
  - A read issued in cycle N sets rd_pend and records rd_src.
  - Cycle N+1, rd_src=ACC: acc_rvalid=1 and acc_rpatch=sram_dout0 (combinational pass-through).
  - Cycle N+1, rd_src=WBS: wbs_qp_mem_rpatch0 captures sram_dout0 at the end of N+1, is visible from N+2, and holds until the next Wishbone read.
  - Back-to-back accelerator reads give one read per cycle.
- Out-of-range (addr >= NUM_QUERYS) from either master:
  - SRAM is not enabled (csb0 stays 1).
  - addr_err is set and stays set until reset.
  - A read still completes its handshake: accelerator gets acc_rvalid with acc_rpatch=0; Wishbone rpatch0 loads 0.
- stall_cnt increments each cycle acc_req_valid=1 and acc_req_ready=0, saturating at 16'hFFFF.
- A mode change in the same cycle as a request: the request follows the current state's rules; the transition takes effect next cycle.
- Reset mid-read: pending state is cleared and no rvalid is emitted after reset.

Decomposition:
- Shared package (kd_pkg):
  - patch_t (PATCH_SIZE × DATA_WIDTH packed)
  - owner_e {ACC, WBS}
  - state_e {ACC_OWN, WBS_OWN, DRAIN}
  - NUM_QUERYS and ADDRW derived constants
- One natural sub-module: qp_rd_tracker (rd_pend, rd_src, response steering, rpatch hold register).

Test Plan:
- Accelerator read/write after reset:
  - Write addr 5 = 55'h12_3456_789A_BCDE with wbs_mode=0, then read addr 5 → acc_rvalid exactly 1 cycle later with that data; stall_cnt=0.
- Mode switch with read in flight:
  - Accelerator read of addr 7 while wbs_mode rises the same cycle → acc_rvalid still fires next cycle; DRAIN then WBS_OWN; acc_req_ready=0 thereafter.
- Wishbone hold:
  - In WBS_OWN, read addr 2 with the SRAM model returning 55'h00_1010_DEAD_BEEF → rpatch0 equals that value from N+2 and stays put across 10 idle cycles and a Wishbone write.
- Out of range:
  - Accelerator read of addr 408 → sram_csb0 stays 1; acc_rvalid=1 with acc_rpatch=0; addr_err=1 and remains 1 after further legal accesses.
- Stall counting:
  - acc_req_valid held high for 20 cycles in WBS_OWN → stall_cnt=20.
  - Forcing the counter to 16'hFFFF → it holds at FFFF.
- Drain abort and reset:
  - wbs_mode pulses high for 1 cycle during ACC_OWN → returns to ACC_OWN, no Wishbone access.
  - rst_n asserted mid-read → acc_rvalid never asserts and all outputs return to reset values asynchronously.
